// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants, FSM state type and the LFSR step function used by the
// LFSR decryption engine (and usable by any encryption-side model).
//   SRC_BASE / DST_BASE : ciphertext / plaintext base addresses in data memory
//   MSG_LEN             : bytes per block
//   PRE_MIN             : guaranteed number of leading spaces in the plaintext
//   TAPS                : the nine legal feedback tap masks, index 0..8
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam logic [7:0] SRC_BASE = 8'd64;
   localparam logic [7:0] DST_BASE = 8'd0;
   localparam int         MSG_LEN  = 64;
   localparam int         PRE_MIN  = 10;
   localparam int         NUM_PTRN = 9;
   localparam logic [7:0] SPACE    = 8'h20;

   localparam logic [6:0] TAPS [NUM_PTRN] = '{
      7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
   };

   typedef enum logic [2:0] {
      IDLE, LOAD, SEED, SEARCH, DECRYPT, PAD, DONE
   } state_t;

   // Shift left, feedback bit is the parity of the tapped state bits.
   function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
      return {s[5:0], ^(s & taps)};
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// 7-bit LFSR state register. Load has priority over step. The next state is
// also exposed combinationally so the caller can compare against it before
// committing the step.
//   clk, srst   : clock, synchronous active-high reset
//   load        : state <= load_val
//   load_val    : value to load
//   step        : state <= state_next
//   tap_sel     : tap pattern index 0..8
//   state       : current LFSR state
//   state_next  : state after one step with the selected taps
// -----------------------------------------------------------------------------
module lfsr_core
   import lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic       load,
   input  logic [6:0] load_val,
   input  logic       step,
   input  logic [3:0] tap_sel,
   output logic [6:0] state,
   output logic [6:0] state_next
);

   logic [6:0] state_q;
   logic [6:0] state_d;

   assign state_next = lfsr_step(state_q, TAPS[tap_sel]);
   assign state      = state_q;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (step) begin
         state_d = state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/lfsr_decrypt.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt
// Recovers the LFSR seed and tap pattern of an encrypted 64-byte block from
// its space preamble, decrypts it, drops leading spaces and writes the
// plaintext (space padded) back to data memory.
//   Clk, Reset           : clock, synchronous active-high reset
//   Start / Ack          : launch on first low cycle after high; Ack held in DONE
//   MemAddr/MemRdEn/...  : single data-memory port, read data one cycle later
//   PtrnIdx, LfsrInit    : recovered tap index and seed
//   NoMatch              : no tap pattern fits the preamble
//   ParityErrs           : saturating count of bytes with a bad parity bit
// The memory strobes are decoded from registered state in the same cycle so a
// byte can be read and conditionally written in two cycles; they are forced
// low while Reset is high so an aborted run cannot commit a write.
// -----------------------------------------------------------------------------
module lfsr_decrypt
   import lfsr_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] MemAddr,
   output logic       MemRdEn,
   input  logic [7:0] MemRdData,
   output logic       MemWrEn,
   output logic [7:0] MemWrData,
   output logic [3:0] PtrnIdx,
   output logic [6:0] LfsrInit,
   output logic       NoMatch,
   output logic [6:0] ParityErrs
);

   localparam logic [3:0] LOAD_LAST  = 4'(PRE_MIN);
   localparam logic [3:0] CHECK_LAST = 4'(PRE_MIN - 1);
   localparam logic [3:0] PTRN_LAST  = 4'(NUM_PTRN - 1);
   localparam logic [5:0] BYTE_LAST  = 6'(MSG_LEN - 1);
   localparam logic [6:0] DST_LAST   = 7'(MSG_LEN - 1);
   localparam logic [6:0] DST_FULL   = 7'(MSG_LEN);

   state_t     state_q, state_d;
   logic       arm_q, arm_d;
   logic       ack_q, ack_d;
   logic [3:0] ptrn_q, ptrn_d;
   logic [6:0] init_q, init_d;
   logic       nomatch_q, nomatch_d;
   logic [6:0] perr_q, perr_d;
   logic [3:0] cnt_q, cnt_d;        // LOAD cycle / SEARCH step index
   logic [3:0] p_q, p_d;            // pattern under test
   logic [5:0] byte_q, byte_d;      // ciphertext byte index
   logic       phase_q, phase_d;    // 0: read, 1: write
   logic [6:0] dst_q, dst_d;        // plaintext bytes written so far
   logic       lead_q, lead_d;      // still inside the leading spaces
   logic [6:0] buf_q [PRE_MIN];
   logic [6:0] buf_d [PRE_MIN];

   logic       core_load;
   logic       core_step;
   logic [6:0] core_state;
   logic [6:0] core_next;
   logic [6:0] seed;
   logic [7:0] plain;
   logic       skip;
   logic       mem_rd, mem_wr;
   logic [7:0] mem_addr, mem_wdata;

   // Preamble byte 0 is a space, so its ciphertext is the seed XOR 0x20.
   assign seed  = buf_q[0] ^ SPACE[6:0];
   assign plain = {1'b0, MemRdData[6:0] ^ core_state};
   assign skip  = lead_q && (plain == SPACE);

   lfsr_core u_core (
      .clk        (Clk),
      .srst       (Reset),
      .load       (core_load),
      .load_val   (seed),
      .step       (core_step),
      .tap_sel    (p_q),
      .state      (core_state),
      .state_next (core_next)
   );

   always_comb begin
      state_d   = state_q;
      arm_d     = arm_q;
      ack_d     = ack_q;
      ptrn_d    = ptrn_q;
      init_d    = init_q;
      nomatch_d = nomatch_q;
      perr_d    = perr_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      byte_d    = byte_q;
      phase_d   = phase_q;
      dst_d     = dst_q;
      lead_d    = lead_q;
      buf_d     = buf_q;
      core_load = 1'b0;
      core_step = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (Start) begin
               arm_d = 1'b1;
            end else if (arm_q) begin
               arm_d     = 1'b0;
               ack_d     = 1'b0;
               ptrn_d    = '0;
               init_d    = '0;
               nomatch_d = 1'b0;
               perr_d    = '0;
               cnt_d     = '0;
               state_d   = LOAD;
            end
         end

         LOAD: begin
            // Read issued in cycle n lands in cycle n+1, hence the offset capture.
            if (cnt_q < LOAD_LAST) begin
               mem_rd   = 1'b1;
               mem_addr = SRC_BASE + {4'd0, cnt_q};
            end
            if (cnt_q != 4'd0) begin
               buf_d[cnt_q - 4'd1] = MemRdData[6:0];
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LOAD_LAST) begin
               state_d = SEED;
            end
         end

         SEED: begin
            if (seed == 7'd0) begin
               nomatch_d = 1'b1;
               ack_d     = 1'b1;
               state_d   = DONE;
            end else begin
               init_d    = seed;
               p_d       = '0;
               cnt_d     = 4'd1;
               core_load = 1'b1;
               state_d   = SEARCH;
            end
         end

         SEARCH: begin
            if ((buf_q[cnt_q] ^ core_next) != SPACE[6:0]) begin
               if (p_q == PTRN_LAST) begin
                  nomatch_d = 1'b1;
                  ack_d     = 1'b1;
                  state_d   = DONE;
               end else begin
                  p_d       = p_q + 4'd1;
                  cnt_d     = 4'd1;
                  core_load = 1'b1;
               end
            end else if (cnt_q == CHECK_LAST) begin
               ptrn_d    = p_q;
               core_load = 1'b1;
               byte_d    = '0;
               phase_d   = 1'b0;
               dst_d     = '0;
               lead_d    = 1'b1;
               state_d   = DECRYPT;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + 4'd1;
            end
         end

         DECRYPT: begin
            if (!phase_q) begin
               mem_rd   = 1'b1;
               mem_addr = SRC_BASE + {2'd0, byte_q};
               phase_d  = 1'b1;
            end else begin
               phase_d   = 1'b0;
               core_step = 1'b1;
               byte_d    = byte_q + 6'd1;
               if ((MemRdData[7] != (^MemRdData[6:0])) && (perr_q != 7'h7F)) begin
                  perr_d = perr_q + 7'd1;
               end
               if (!skip) begin
                  mem_wr    = 1'b1;
                  mem_addr  = DST_BASE + {1'b0, dst_q};
                  mem_wdata = plain;
                  dst_d     = dst_q + 7'd1;
                  lead_d    = 1'b0;
               end
               if (byte_q == BYTE_LAST) begin
                  if (dst_d == DST_FULL) begin
                     ack_d   = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = PAD;
                  end
               end
            end
         end

         PAD: begin
            mem_wr    = 1'b1;
            mem_addr  = DST_BASE + {1'b0, dst_q};
            mem_wdata = SPACE;
            dst_d     = dst_q + 7'd1;
            if (dst_q == DST_LAST) begin
               ack_d   = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            if (Start) begin
               arm_d   = 1'b1;
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         arm_q     <= 1'b0;
         ack_q     <= 1'b0;
         ptrn_q    <= '0;
         init_q    <= '0;
         nomatch_q <= 1'b0;
         perr_q    <= '0;
         cnt_q     <= '0;
         p_q       <= '0;
         byte_q    <= '0;
         phase_q   <= 1'b0;
         dst_q     <= '0;
         lead_q    <= 1'b0;
         buf_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         arm_q     <= arm_d;
         ack_q     <= ack_d;
         ptrn_q    <= ptrn_d;
         init_q    <= init_d;
         nomatch_q <= nomatch_d;
         perr_q    <= perr_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         byte_q    <= byte_d;
         phase_q   <= phase_d;
         dst_q     <= dst_d;
         lead_q    <= lead_d;
         buf_q     <= buf_d;
      end
   end

   assign Ack        = ack_q;
   assign PtrnIdx    = ptrn_q;
   assign LfsrInit   = init_q;
   assign NoMatch    = nomatch_q;
   assign ParityErrs = perr_q;
   assign MemRdEn    = mem_rd & ~Reset;
   assign MemWrEn    = mem_wr & ~Reset;
   assign MemAddr    = Reset ? 8'd0 : mem_addr;
   assign MemWrData  = Reset ? 8'd0 : mem_wdata;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// -----------------------------------------------------------------------------
// tb_lfsr_decrypt
// Encrypts messages with its own LFSR model, places the ciphertext in a
// behavioural data memory, runs lfsr_decrypt and compares status outputs and
// the plaintext area against the message or the reference decryptor.
// -----------------------------------------------------------------------------
module tb_lfsr_decrypt;

   logic       Clk   = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Ack;
   logic [7:0] MemAddr;
   logic       MemRdEn;
   logic [7:0] MemRdData;
   logic       MemWrEn;
   logic [7:0] MemWrData;
   logic [3:0] PtrnIdx;
   logic [6:0] LfsrInit;
   logic       NoMatch;
   logic [6:0] ParityErrs;

   lfsr_decrypt dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Ack        (Ack),
      .MemAddr    (MemAddr),
      .MemRdEn    (MemRdEn),
      .MemRdData  (MemRdData),
      .MemWrEn    (MemWrEn),
      .MemWrData  (MemWrData),
      .PtrnIdx    (PtrnIdx),
      .LfsrInit   (LfsrInit),
      .NoMatch    (NoMatch),
      .ParityErrs (ParityErrs)
   );

   always #5 Clk = ~Clk;

   // ---------------- data memory ----------------
   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic       load_req       = 1'b0;
   int         wr_total       = 0;
   int         conflict_total = 0;

   always @(posedge Clk) begin
      if (load_req) begin
         for (int a = 0; a < 256; a++) mem[a] <= img[a];
      end else if (MemWrEn) begin
         mem[MemAddr] <= MemWrData;
      end
      if (MemRdEn) MemRdData <= mem[MemAddr];
      if (MemWrEn) wr_total <= wr_total + 1;
      if (MemRdEn && MemWrEn) conflict_total <= conflict_total + 1;
   end

   // ---------------- reference model ----------------
   logic [6:0] tap_tbl [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
   logic [7:0] plain_in  [64];
   logic [7:0] cipher    [64];
   logic [7:0] exp_plain [64];
   int         exp_ptrn, exp_init, exp_nomatch, exp_perr, exp_writes;

   int n_checks = 0;
   int n_pass   = 0;
   int run_writes;
   int run_cycles;

   function automatic logic [6:0] next_state(input logic [6:0] s, input int pt);
      int fb;
      fb = $countones(s & tap_tbl[pt]) % 2;
      return 7'((int'(s) * 2 + fb) % 128);
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_plain(input string msg, input int pre);
      for (int i = 0; i < 64; i++) begin
         if (i >= pre && (i - pre) < msg.len()) plain_in[i] = msg[i - pre];
         else plain_in[i] = 8'h20;
      end
   endtask

   task automatic encrypt(input int pt, input logic [6:0] init);
      logic [6:0] s, x;
      s = init;
      for (int i = 0; i < 64; i++) begin
         x = plain_in[i][6:0] ^ s;
         cipher[i] = {1'($countones(x) % 2), x};
         s = next_state(s, pt);
      end
   endtask

   // Seed from the first space, first pattern whose keystream turns all
   // preamble bytes into spaces, then decrypt and drop leading spaces.
   task automatic model_decrypt();
      logic [6:0] s0, s, pl;
      bit ok, lead;
      int d;
      exp_nomatch = 0; exp_ptrn = 0; exp_perr = 0; exp_writes = 0;
      for (int i = 0; i < 64; i++) exp_plain[i] = 8'h20;
      s0 = cipher[0][6:0] ^ 7'h20;
      exp_init = s0;
      if (s0 == 7'd0) begin exp_nomatch = 1; return; end
      exp_ptrn = -1;
      for (int p = 0; p < 9 && exp_ptrn < 0; p++) begin
         s = s0; ok = 1;
         for (int k = 1; k < 10; k++) begin
            s = next_state(s, p);
            if ((cipher[k][6:0] ^ s) != 7'h20) ok = 0;
         end
         if (ok) exp_ptrn = p;
      end
      if (exp_ptrn < 0) begin exp_nomatch = 1; exp_ptrn = 0; return; end
      s = s0; d = 0; lead = 1;
      for (int i = 0; i < 64; i++) begin
         pl = cipher[i][6:0] ^ s;
         if (cipher[i][7] != 1'($countones(cipher[i][6:0]) % 2) && exp_perr < 127) exp_perr++;
         if (!(lead && pl == 7'h20)) begin
            exp_plain[d] = {1'b0, pl};
            d++;
            lead = 0;
         end
         s = next_state(s, exp_ptrn);
      end
      exp_writes = 64;
   endtask

   task automatic load_image();
      for (int a = 0; a < 256; a++) begin
         if (a < 64)       img[a] = 8'hA5 ^ 8'(a);
         else if (a < 128) img[a] = cipher[a - 64];
         else              img[a] = 8'h00;
      end
      @(negedge Clk); load_req = 1'b1;
      @(negedge Clk); load_req = 1'b0;
   endtask

   task automatic run_block(input string name);
      int w0, c0;
      w0 = wr_total;
      c0 = conflict_total;
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      run_cycles = 0;
      while (!Ack && run_cycles < 1000) begin
         @(negedge Clk);
         run_cycles++;
      end
      run_writes = wr_total - w0;
      check_eq({name, ".ack"}, int'(Ack), 1);
      check_eq({name, ".latency_ok"}, int'(run_cycles <= 290), 1);
      check_eq({name, ".rd_wr_overlap"}, conflict_total - c0, 0);
      $display("run %s: ptrn=%0d init=0x%02h nomatch=%0d perr=%0d writes=%0d cycles=%0d",
               name, PtrnIdx, LfsrInit, NoMatch, ParityErrs, run_writes, run_cycles);
   endtask

   task automatic release_block(input string name);
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk);
      check_eq({name, ".ack_release"}, int'(Ack), 0);
   endtask

   task automatic check_status(input string name, input int pt, input int init,
                               input int nm, input int perr, input int writes);
      check_eq({name, ".PtrnIdx"}, int'(PtrnIdx), pt);
      check_eq({name, ".LfsrInit"}, int'(LfsrInit), init);
      check_eq({name, ".NoMatch"}, int'(NoMatch), nm);
      check_eq({name, ".ParityErrs"}, int'(ParityErrs), perr);
      check_eq({name, ".writes"}, run_writes, writes);
   endtask

   task automatic check_plain_msg(input string name, input string s);
      for (int i = 0; i < 64; i++)
         check_eq($sformatf("%s.dm[%0d]", name, i), int'(mem[i]),
                  (i < s.len()) ? int'(s[i]) : 32'h20);
   endtask

   task automatic check_plain_model(input string name);
      for (int i = 0; i < 64; i++)
         check_eq($sformatf("%s.dm[%0d]", name, i), int'(mem[i]), int'(exp_plain[i]));
   endtask

   task automatic check_untouched(input string name);
      for (int i = 0; i < 64; i++)
         check_eq($sformatf("%s.dm[%0d]", name, i), int'(mem[i]), int'(8'hA5 ^ 8'(i)));
   endtask

   localparam string MSG   = " Knowledge comes, but wisdom lingers.";
   localparam string PLAIN = "Knowledge comes, but wisdom lingers.";

   initial begin
      int cyc, pre, len, pt, nflip;
      logic [6:0] init;
      string nm;

      // ---- reset state ----
      repeat (3) @(negedge Clk);
      check_eq("reset.Ack", int'(Ack), 0);
      check_eq("reset.MemRdEn", int'(MemRdEn), 0);
      check_eq("reset.MemWrEn", int'(MemWrEn), 0);
      check_eq("reset.PtrnIdx", int'(PtrnIdx), 0);
      check_eq("reset.LfsrInit", int'(LfsrInit), 0);
      check_eq("reset.NoMatch", int'(NoMatch), 0);
      check_eq("reset.ParityErrs", int'(ParityErrs), 0);
      Reset = 1'b0;

      // ---- case 1: pattern 0 ----
      set_plain(MSG, 12); encrypt(0, 7'h17); load_image();
      run_block("c1");
      check_status("c1", 0, 'h17, 0, 0, 64);
      check_plain_msg("c1", PLAIN);
      release_block("c1");

      // ---- case 2: last pattern ----
      set_plain(MSG, 15); encrypt(8, 7'h7F); load_image();
      run_block("c2");
      check_status("c2", 8, 'h7F, 0, 0, 64);
      check_plain_msg("c2", PLAIN);
      release_block("c2");

      // ---- case 3: two parity errors ----
      set_plain(MSG, 12); encrypt(0, 7'h17);
      cipher[20][7] = ~cipher[20][7];
      cipher[40][7] = ~cipher[40][7];
      load_image();
      run_block("c3");
      check_status("c3", 0, 'h17, 0, 2, 64);
      check_plain_msg("c3", PLAIN);
      release_block("c3");

      // ---- case 4: zero seed ----
      for (int i = 0; i < 64; i++) cipher[i] = 8'($urandom_range(0, 255));
      cipher[0] = 8'h20;
      load_image();
      run_block("c4");
      check_status("c4", 0, 0, 1, 0, 0);
      check_untouched("c4");
      release_block("c4");

      // ---- case 5: all spaces ----
      set_plain("", 64); encrypt(3, 7'h01); load_image();
      run_block("c5");
      check_status("c5", 3, 'h01, 0, 0, 64);
      check_plain_msg("c5", "");
      release_block("c5");

      // ---- case 6: reset mid-decrypt, then relaunch ----
      set_plain(MSG, 12); encrypt(0, 7'h17); load_image();
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      cyc = 0;
      while (!(MemRdEn && MemAddr == 8'd94) && cyc < 1000) begin
         @(negedge Clk);
         cyc++;
      end
      check_eq("c6.reached_byte30", int'(MemRdEn && MemAddr == 8'd94), 1);
      Reset = 1'b1;
      @(negedge Clk);
      check_eq("c6.rst.MemWrEn", int'(MemWrEn), 0);
      check_eq("c6.rst.MemRdEn", int'(MemRdEn), 0);
      check_eq("c6.rst.Ack", int'(Ack), 0);
      check_eq("c6.rst.LfsrInit", int'(LfsrInit), 0);
      check_eq("c6.rst.ParityErrs", int'(ParityErrs), 0);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("c6.no_relaunch", int'(MemRdEn), 0);
      run_block("c6");
      check_status("c6", 0, 'h17, 0, 0, 64);
      check_plain_msg("c6", PLAIN);
      release_block("c6");

      // ---- randomized blocks against the reference decryptor ----
      for (int r = 0; r < 5; r++) begin
         pt   = $urandom_range(0, 8);
         init = 7'($urandom_range(1, 127));
         pre  = $urandom_range(10, 20);
         len  = $urandom_range(0, 64 - pre);
         for (int i = 0; i < 64; i++)
            plain_in[i] = (i >= pre && i < pre + len) ? 8'($urandom_range(32, 126)) : 8'h20;
         encrypt(pt, init);
         nflip = $urandom_range(0, 4);
         for (int f = 0; f < nflip; f++) begin
            int b;
            b = $urandom_range(0, 63);
            cipher[b][7] = ~cipher[b][7];
         end
         model_decrypt();
         load_image();
         nm = $sformatf("rnd%0d", r);
         run_block(nm);
         check_status(nm, exp_ptrn, exp_init, exp_nomatch, exp_perr, exp_writes);
         check_plain_model(nm);
         release_block(nm);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
